hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake bundle for hazard_scoreboard.
// The master side is the decode stage. It drives the instruction fields,
// flush and mem_wait, and it receives stall, issue and the registered
// operand-bypass selects.
// The slave side is the scoreboard.
// Ports:
//   d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
//   d_rd, d_rd_we, d_is_load             : decode instruction fields
//   flush, mem_wait                      : pipeline control
//   stall, issue                         : decode hold / instruction enters X
//   x_byp_rs1_sel, x_byp_rs2_sel         : operand source for the X instruction
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int N_STAGES = 3
);
  localparam int RA = $clog2(NUM_REGS);
  localparam int SW = $clog2(N_STAGES);

  logic          d_valid;
  logic [RA-1:0] d_rs1;
  logic [RA-1:0] d_rs2;
  logic          d_use_rs1;
  logic          d_use_rs2;
  logic [RA-1:0] d_rd;
  logic          d_rd_we;
  logic          d_is_load;
  logic          flush;
  logic          mem_wait;
  logic          stall;
  logic          issue;
  logic [SW-1:0] x_byp_rs1_sel;
  logic [SW-1:0] x_byp_rs2_sel;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
           d_rd, d_rd_we, d_is_load, flush, mem_wait,
    input  stall, issue, x_byp_rs1_sel, x_byp_rs2_sel
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
           d_rd, d_rd_we, d_is_load, flush, mem_wait,
    output stall, issue, x_byp_rs1_sel, x_byp_rs2_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard with bypass-select generation.
// The scoreboard tracks the destination registers of the instructions that
// are in flight in stages X..W, using a shift queue whose index 0 is X.
// It detects read-after-write hazards for the instruction in decode and
// registers the operand bypass source that the instruction uses once it
// reaches X.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   dec           : decode handshake (slave side of hazard_scoreboard_if)
//   busy          : bit r set while a valid in-flight entry writes r
//   stall_cycles  : saturating count of hazard stall cycles
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int N_STAGES   = 3,
  parameter int ALU_STAGE  = 1,
  parameter int LOAD_STAGE = 2
) (
  input  logic                clock,
  input  logic                reset,
  hazard_scoreboard_if.slave  dec,
  output logic [NUM_REGS-1:0] busy,
  output logic [15:0]         stall_cycles
);
  localparam int RA = $clog2(NUM_REGS);
  localparam int SW = $clog2(N_STAGES);

  // In-flight queue: index 0 = X, index N_STAGES-1 = W.
  logic [N_STAGES-1:0]         valid_reg;
  logic [N_STAGES-1:0][RA-1:0] rd_reg;
  logic [N_STAGES-1:0]         we_reg;
  logic [N_STAGES-1:0][SW-1:0] rdy_reg;

  logic [SW-1:0] rs1_sel_reg, rs2_sel_reg;
  logic [SW-1:0] rs1_sel_next, rs2_sel_next;
  logic          rs1_haz, rs2_haz;
  logic          hazard, stall_int, issue_int;
  logic [15:0]   stall_cycles_reg;
  logic [NUM_REGS-1:0] busy_next;

  logic [N_STAGES-1:0] match1, match2;

  // Per-entry source matches; x0 never matches because it is hardwired.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_match
    assign match1[gi] = dec.d_use_rs1 && (dec.d_rs1 != '0) && valid_reg[gi] &&
                        we_reg[gi] && (rd_reg[gi] == dec.d_rs1);
    assign match2[gi] = dec.d_use_rs2 && (dec.d_rs2 != '0) && valid_reg[gi] &&
                        we_reg[gi] && (rd_reg[gi] == dec.d_rs2);
  end

  // The loops scan from oldest to youngest, so the youngest match is
  // applied last and wins. A producer at stage k has moved to k+1 by the
  // time the consumer reaches X. A producer in W has been written to the
  // write-first register file, so it needs no bypass (select 0).
  always_comb begin
    rs1_haz      = 1'b0;
    rs2_haz      = 1'b0;
    rs1_sel_next = '0;
    rs2_sel_next = '0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (match1[k]) begin
        if (k + 1 < int'(rdy_reg[k])) begin
          rs1_haz      = 1'b1;
          rs1_sel_next = '0;
        end else begin
          rs1_haz      = 1'b0;
          rs1_sel_next = (k + 1 <= N_STAGES - 1) ? SW'(k + 1) : '0;
        end
      end
      if (match2[k]) begin
        if (k + 1 < int'(rdy_reg[k])) begin
          rs2_haz      = 1'b1;
          rs2_sel_next = '0;
        end else begin
          rs2_haz      = 1'b0;
          rs2_sel_next = (k + 1 <= N_STAGES - 1) ? SW'(k + 1) : '0;
        end
      end
    end
  end

  // flush beats a hazard; mem_wait freezes everything.
  always_comb begin
    hazard    = dec.d_valid & (rs1_haz | rs2_haz);
    stall_int = dec.mem_wait | (hazard & ~dec.flush);
    issue_int = dec.d_valid & ~stall_int & ~dec.flush;
  end

  always_comb begin
    busy_next = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (valid_reg[k] && we_reg[k]) begin
        busy_next[rd_reg[k]] = 1'b1;
      end
    end
  end

  // Queue shift: entry 0 takes the issuing instruction or a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      rd_reg    <= '0;
      we_reg    <= '0;
      rdy_reg   <= '0;
    end else if (!dec.mem_wait) begin
      valid_reg[0] <= issue_int;
      rd_reg[0]    <= dec.d_rd;
      we_reg[0]    <= issue_int & dec.d_rd_we & (dec.d_rd != '0);
      rdy_reg[0]   <= dec.d_is_load ? SW'(LOAD_STAGE) : SW'(ALU_STAGE);
      for (int k = 1; k < N_STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
        we_reg[k]    <= we_reg[k-1];
        rdy_reg[k]   <= rdy_reg[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rs1_sel_reg <= '0;
      rs2_sel_reg <= '0;
    end else if (!dec.mem_wait) begin
      rs1_sel_reg <= issue_int ? rs1_sel_next : '0;
      rs2_sel_reg <= issue_int ? rs2_sel_next : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (hazard && !dec.flush && !dec.mem_wait &&
                 (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign dec.stall         = stall_int;
  assign dec.issue         = issue_int;
  assign dec.x_byp_rs1_sel = rs1_sel_reg;
  assign dec.x_byp_rs2_sel = rs2_sel_reg;
  assign busy              = busy_next;
  assign stall_cycles      = stall_cycles_reg;
endmodule
